// File: rtl/pmc_readout_if.sv
// Byte-wide valid/ready link between the PMC readout framer and a byte transmitter.
// The master offers tx_data/tx_valid and the slave answers with tx_ready.
interface pmc_readout_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/pmc_readout.sv
// Snapshots the four PMC counters on start and streams them as
// header, 16 payload bytes (LSB first per counter) and an XOR checksum.
module pmc_readout #(
  parameter int          DATA_W = 32,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] stall_count,
  input  logic [DATA_W-1:0] instr_cycle_count,
  input  logic [DATA_W-1:0] arith_count,
  input  logic [DATA_W-1:0] mem_access_count,
  pmc_readout_if.master     tx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CHECKSUM,
    ST_DONE
  } state_t;

  state_t              state;
  logic [4*DATA_W-1:0] snapshot;
  logic [3:0]          byte_idx;
  logic [3:0]          next_idx;
  logic [7:0]          checksum;
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;
  logic                handshake;

  assign handshake   = tx_valid_q & tx.tx_ready;
  assign next_idx    = byte_idx + 4'd1;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;

  // tx_data is loaded one byte ahead so it is already stable when tx_valid is seen
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      snapshot   <= '0;
      byte_idx   <= '0;
      checksum   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            snapshot   <= {mem_access_count, arith_count, instr_cycle_count, stall_count};
            checksum   <= '0;
            byte_idx   <= '0;
            tx_data_q  <= HEADER;
            tx_valid_q <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_HEADER;
          end
        end

        ST_HEADER: begin
          if (handshake) begin
            byte_idx  <= '0;
            tx_data_q <= snapshot[7:0];
            state     <= ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          if (handshake) begin
            checksum <= checksum ^ tx_data_q;
            if (byte_idx == 4'd15) begin
              tx_data_q <= checksum ^ tx_data_q;
              state     <= ST_CHECKSUM;
            end else begin
              byte_idx  <= next_idx;
              tx_data_q <= snapshot[{next_idx, 3'b000} +: 8];
            end
          end
        end

        ST_CHECKSUM: begin
          if (handshake) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= ST_DONE;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          tx_valid_q <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmc_readout.sv
// Directed, table-driven bench for pmc_readout: frame contents, stalls,
// snapshot isolation, reset abort and back-to-back frames.
module tb_pmc_readout;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] stall_count;
  logic [31:0] instr_cycle_count;
  logic [31:0] arith_count;
  logic [31:0] mem_access_count;
  logic        busy;
  logic        done;

  pmc_readout_if tx ();

  pmc_readout dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .stall_count       (stall_count),
    .instr_cycle_count (instr_cycle_count),
    .arith_count       (arith_count),
    .mem_access_count  (mem_access_count),
    .tx                (tx),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] stall;
    logic [31:0] instr;
    logic [31:0] arith;
    logic [31:0] mem;
    logic [7:0]  csum;
    bit          slow_ready;
    bit          corrupt;
  } vec_t;

  vec_t vecs [5];
  int   checks_total  = 0;
  int   checks_passed = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic logic [7:0] expected_byte(input vec_t v, input int i);
    logic [127:0] words;
    words = {v.mem, v.arith, v.instr, v.stall};
    if (i == 0) return 8'hA5;
    if (i == 17) return v.csum;
    return words[(i-1)*8 +: 8];
  endfunction

  // Runs one frame from IDLE; inputs change and outputs are sampled on negedges
  task automatic apply_stimulus(input vec_t v);
    int   cycle;
    int   got;
    int   accept_cycle;
    logic prev_stalled;
    logic [7:0] prev_data;
    logic ready;
    stall_count       = v.stall;
    instr_cycle_count = v.instr;
    arith_count       = v.arith;
    mem_access_count  = v.mem;
    start       = 1'b1;
    tx.tx_ready = 1'b0;
    @(negedge clk);
    cycle = 1;
    start = 1'b0;
    if (v.corrupt) begin
      stall_count       = 32'hFFFF_FFFF;
      instr_cycle_count = 32'hFFFF_FFFF;
      arith_count       = 32'hFFFF_FFFF;
      mem_access_count  = 32'hFFFF_FFFF;
    end
    got          = 0;
    accept_cycle = 0;
    prev_stalled = 1'b0;
    prev_data    = 8'h00;
    while (got < 18 && cycle < 200) begin
      if (prev_stalled) begin
        check_output("stall_valid_held", tx.tx_valid, 1'b1);
        check_output("stall_data_held", tx.tx_data, prev_data);
      end
      ready = v.slow_ready ? ((cycle % 3) == 0) : 1'b1;
      if (tx.tx_valid) begin
        check_output("busy_in_frame", busy, 1'b1);
        if (ready) begin
          check_output($sformatf("frame_byte%0d", got), tx.tx_data, expected_byte(v, got));
          got++;
          if (got == 18) accept_cycle = cycle;
        end
      end
      prev_stalled = tx.tx_valid & ~ready;
      prev_data    = tx.tx_data;
      tx.tx_ready  = ready;
      @(negedge clk);
      cycle++;
    end
    if (got < 18) check_output("frame_timeout", got, 18);
    if (!v.slow_ready) check_output("checksum_cycle", accept_cycle, 18);
    check_output("done_pulse", done, 1'b1);
    check_output("done_busy", busy, 1'b0);
    check_output("done_valid", tx.tx_valid, 1'b0);
    @(negedge clk);
    check_output("done_cleared", done, 1'b0);
    check_output("idle_valid", tx.tx_valid, 1'b0);
    tx.tx_ready = 1'b0;
  endtask

  initial begin
    int got;
    int phase;
    vecs[0] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0010, 32'h0000_0100, 8'h12, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0010, 32'h0000_0100, 8'h12, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0010, 32'h0000_0100, 8'h12, 1'b0, 1'b1};
    vecs[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0080, 32'hA5A5_A5A5, 8'h80, 1'b1, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b0};

    reset             = 1'b1;
    start             = 1'b0;
    stall_count       = '0;
    instr_cycle_count = '0;
    arith_count       = '0;
    mem_access_count  = '0;
    tx.tx_ready       = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_valid", tx.tx_valid, 1'b0);
    check_output("reset_data", tx.tx_data, 8'h00);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_done", done, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tx.tx_ready = i[0];
      @(negedge clk);
      check_output("idle_valid", tx.tx_valid, 1'b0);
      check_output("idle_busy", busy, 1'b0);
      check_output("idle_done", done, 1'b0);
    end
    tx.tx_ready = 1'b0;

    for (int i = 0; i < 5; i++) begin
      $display("[TB] frame vector %0d", i);
      apply_stimulus(vecs[i]);
      @(negedge clk);
    end

    $display("[TB] reset during payload");
    stall_count       = vecs[3].stall;
    instr_cycle_count = vecs[3].instr;
    arith_count       = vecs[3].arith;
    mem_access_count  = vecs[3].mem;
    start = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    tx.tx_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 50; c++) begin
      if (tx.tx_valid && got == 7) break;
      if (tx.tx_valid) got++;
      @(negedge clk);
    end
    check_output("abort_byte_offered", tx.tx_data, 8'hBC);
    reset       = 1'b1;
    tx.tx_ready = 1'b0;
    @(negedge clk);
    check_output("abort_valid", tx.tx_valid, 1'b0);
    check_output("abort_busy", busy, 1'b0);
    check_output("abort_done", done, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    apply_stimulus(vecs[0]);
    @(negedge clk);

    $display("[TB] start held high");
    stall_count       = vecs[0].stall;
    instr_cycle_count = vecs[0].instr;
    arith_count       = vecs[0].arith;
    mem_access_count  = vecs[0].mem;
    tx.tx_ready = 1'b1;
    start       = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      phase = k % 20;
      check_output($sformatf("hold_valid_c%0d", k), tx.tx_valid, (phase >= 1 && phase <= 18));
      check_output($sformatf("hold_done_c%0d", k), done, (phase == 19));
      if (phase == 1) check_output($sformatf("hold_header_c%0d", k), tx.tx_data, 8'hA5);
      if (phase == 18) check_output($sformatf("hold_csum_c%0d", k), tx.tx_data, 8'h12);
    end
    start       = 1'b0;
    tx.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_output("final_idle_busy", busy, 1'b0);
    check_output("final_idle_valid", tx.tx_valid, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
